// File: rtl/mem_copy_dma_pkg.sv
// Shared types and defaults for the memory copy engine.
package mem_copy_dma_pkg;
   localparam int DEFAULT_DEPTH     = 128;
   localparam int DEFAULT_BIT_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WRITE,
      FILL,
      DONE
   } state_t;
endpackage

// File: rtl/mem_copy_dma.sv
// Word-RAM copy engine: reads LEN words from SRC and writes them to DST in
// ascending order, one READ/WRITE pair per word, while holding the RAM port.
// Optional feature macro MEM_COPY_DMA_FILL_EN adds a fill mode that writes a
// constant pattern to the destination range, one word per cycle.
module mem_copy_dma
   import mem_copy_dma_pkg::*;
#(
   parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter int LEN_W     = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_in,
   input  logic [BIT_WIDTH-1:0] src_in,
   input  logic [BIT_WIDTH-1:0] dst_in,
   input  logic [LEN_W-1:0]     len_in,
`ifdef MEM_COPY_DMA_FILL_EN
   input  logic                 fill_mode_in,
   input  logic [BIT_WIDTH-1:0] fill_pattern_in,
`endif
   input  logic [BIT_WIDTH-1:0] Mem_Read_Data_in,
   output logic [BIT_WIDTH-1:0] Mem_Address_out,
   output logic [BIT_WIDTH-1:0] Mem_Write_Data_out,
   output logic                 MemWrite_out,
   output logic                 busy_out,
   output logic                 done_out,
   output logic                 error_out
);

   // Range sums are formed one bit wider than either operand so that a huge
   // src/dst plus len can never wrap back into the legal window.
   localparam int SUM_W = ((BIT_WIDTH > LEN_W) ? BIT_WIDTH : LEN_W) + 1;

   state_t               state_q, state_d;
   logic [BIT_WIDTH-1:0] src_ptr_q, dst_ptr_q, data_q;
   logic [LEN_W-1:0]     cnt_q;
   logic                 err_q;

   logic                 fill_req;
   logic [BIT_WIDTH-1:0] fill_pat;
   logic [SUM_W-1:0]     src_end, dst_end, depth_lim;
   logic                 src_bad, dst_bad, range_err, len_zero;

`ifdef MEM_COPY_DMA_FILL_EN
   assign fill_req = fill_mode_in;
   assign fill_pat = fill_pattern_in;
`else
   assign fill_req = 1'b0;
   assign fill_pat = '0;
`endif

   assign src_end   = SUM_W'(src_in) + SUM_W'(len_in);
   assign dst_end   = SUM_W'(dst_in) + SUM_W'(len_in);
   assign depth_lim = SUM_W'(DEPTH);
   assign src_bad   = (src_end > depth_lim) && !fill_req;  // fill never reads
   assign dst_bad   = (dst_end > depth_lim);
   assign len_zero  = (len_in == '0);
   // An empty transfer finishes cleanly even if the addresses are odd.
   assign range_err = !len_zero && (src_bad || dst_bad);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and RAM port / status outputs, all decoded from the current state.
   always_comb begin
      state_d            = state_q;
      Mem_Address_out    = '0;
      Mem_Write_Data_out = '0;
      MemWrite_out       = 1'b0;
      done_out           = 1'b0;
      error_out          = 1'b0;
      busy_out           = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (start_in) begin
               if (len_zero || range_err) state_d = DONE;
               else if (fill_req)         state_d = FILL;
               else                       state_d = READ;
            end
         end
         READ: begin
            Mem_Address_out = src_ptr_q;
            state_d         = WRITE;
         end
         WRITE: begin
            Mem_Address_out    = dst_ptr_q;
            Mem_Write_Data_out = data_q;
            MemWrite_out       = 1'b1;
            state_d            = (cnt_q == LEN_W'(1)) ? DONE : READ;
         end
         FILL: begin
            Mem_Address_out    = dst_ptr_q;
            Mem_Write_Data_out = data_q;
            MemWrite_out       = 1'b1;
            state_d            = (cnt_q == LEN_W'(1)) ? DONE : FILL;
         end
         DONE: begin
            done_out  = 1'b1;
            error_out = err_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Transfer bookkeeping: latch the request, capture read data, advance pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         src_ptr_q <= '0;
         dst_ptr_q <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_in) begin
                  src_ptr_q <= src_in;
                  dst_ptr_q <= dst_in;
                  cnt_q     <= len_in;
                  err_q     <= range_err;
                  // Fill mode reuses the data register as the pattern holder.
                  if (fill_req) data_q <= fill_pat;
               end
            end
            READ: data_q <= Mem_Read_Data_in;
            WRITE, FILL: begin
               src_ptr_q <= src_ptr_q + BIT_WIDTH'(1);
               dst_ptr_q <= dst_ptr_q + BIT_WIDTH'(1);
               cnt_q     <= cnt_q - LEN_W'(1);
            end
            DONE: err_q <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma with a behavioural 128-word RAM attached.
module tb_mem_copy_dma;
   localparam int BW  = 32;
   localparam int DP  = 128;
   localparam int LW  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_in;
   logic [BW-1:0] src_in, dst_in;
   logic [LW-1:0] len_in;
`ifdef MEM_COPY_DMA_FILL_EN
   logic          fill_mode_in;
   logic [BW-1:0] fill_pattern_in;
`endif
   logic [BW-1:0] Mem_Read_Data_in, Mem_Address_out, Mem_Write_Data_out;
   logic          MemWrite_out, busy_out, done_out, error_out;

   logic [BW-1:0] ram [0:DP-1];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_copy_dma dut (
      .clk(clk), .rst(rst), .start_in(start_in),
      .src_in(src_in), .dst_in(dst_in), .len_in(len_in),
`ifdef MEM_COPY_DMA_FILL_EN
      .fill_mode_in(fill_mode_in), .fill_pattern_in(fill_pattern_in),
`endif
      .Mem_Read_Data_in(Mem_Read_Data_in), .Mem_Address_out(Mem_Address_out),
      .Mem_Write_Data_out(Mem_Write_Data_out), .MemWrite_out(MemWrite_out),
      .busy_out(busy_out), .done_out(done_out), .error_out(error_out)
   );

   // Combinational-read, posedge-write RAM.
   assign Mem_Read_Data_in = (Mem_Address_out < DP) ? ram[Mem_Address_out[6:0]] : '0;
   always @(posedge clk)
      if (MemWrite_out && Mem_Address_out < DP) ram[Mem_Address_out[6:0]] <= Mem_Write_Data_out;

   // Launch one request and watch it to completion; cycle 1 is the first
   // cycle after the start edge. done_cyc stays 0 if done never arrives.
   task automatic run_xfer(input logic [BW-1:0] s, input logic [BW-1:0] d, input int l,
                           output int done_cyc, output int nwr, output int nbusy, output bit err);
      done_cyc = 0; nwr = 0; nbusy = 0; err = 1'b0;
      @(negedge clk);
      start_in = 1'b1; src_in = s; dst_in = d; len_in = LW'(l);
      @(negedge clk);
      start_in = 1'b0;
      for (int c = 1; c <= 400; c++) begin
         if (busy_out) nbusy++;
         if (MemWrite_out) nwr++;
         if (error_out) err = 1'b1;
         if (done_out) begin done_cyc = c; break; end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      bit ram_ok = 1'b1;
      for (int i = 0; i < DP; i++) ram[i] <= 32'h5A00_0000 | i;
      rst = 1'b1; start_in = 1'b1; src_in = 0; dst_in = 64; len_in = 8'd4;
      repeat (2) @(negedge clk);
      start_in = 1'b0;
      total++; if (Mem_Address_out !== '0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", Mem_Address_out); end
      total++; if (Mem_Write_Data_out !== '0) begin bad++; $display("FAIL reset_wdata got=%0h exp=0", Mem_Write_Data_out); end
      total++; if ({MemWrite_out, busy_out, done_out, error_out} !== 4'b0)
         begin bad++; $display("FAIL reset_flags got=%b exp=0000", {MemWrite_out, busy_out, done_out, error_out}); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy_out); end
      for (int i = 0; i < DP; i++) if (ram[i] !== (32'h5A00_0000 | i)) ram_ok = 1'b0;
      total++; if (!ram_ok) begin bad++; $display("FAIL reset_ram_intact got=changed exp=unchanged"); end
   endtask

   task automatic test_copy();
      int dc, nw, nb; bit er;
      ram[10] <= 32'h1111_AAAA; ram[11] <= 32'h2222_BBBB;
      ram[12] <= 32'h3333_CCCC; ram[13] <= 32'h4444_DDDD;
      run_xfer(10, 40, 4, dc, nw, nb, er);
      total++; if (ram[40] !== 32'h1111_AAAA) begin bad++; $display("FAIL copy_w0 got=%0h exp=1111aaaa", ram[40]); end
      total++; if (ram[41] !== 32'h2222_BBBB) begin bad++; $display("FAIL copy_w1 got=%0h exp=2222bbbb", ram[41]); end
      total++; if (ram[42] !== 32'h3333_CCCC) begin bad++; $display("FAIL copy_w2 got=%0h exp=3333cccc", ram[42]); end
      total++; if (ram[43] !== 32'h4444_DDDD) begin bad++; $display("FAIL copy_w3 got=%0h exp=4444dddd", ram[43]); end
      total++; if (ram[44] !== 32'h5A00_002C) begin bad++; $display("FAIL copy_no_overrun got=%0h exp=5a00002c", ram[44]); end
      total++; if (dc !== 9) begin bad++; $display("FAIL copy_done_cycle got=%0d exp=9", dc); end
      total++; if (nw !== 4) begin bad++; $display("FAIL copy_writes got=%0d exp=4", nw); end
      total++; if (nb !== 9) begin bad++; $display("FAIL copy_busy_cycles got=%0d exp=9", nb); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL copy_error got=%b exp=0", er); end
      total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL copy_back_idle got=%b exp=0", busy_out); end
   endtask

   task automatic test_bounds();
      int dc, nw, nb; bit er;
      run_xfer(10, 50, 0, dc, nw, nb, er);
      total++; if (dc !== 1) begin bad++; $display("FAIL len0_done got=%0d exp=1", dc); end
      total++; if (nw !== 0) begin bad++; $display("FAIL len0_writes got=%0d exp=0", nw); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL len0_error got=%b exp=0", er); end
      run_xfer(126, 50, 3, dc, nw, nb, er);
      total++; if (dc !== 1) begin bad++; $display("FAIL src_oob_done got=%0d exp=1", dc); end
      total++; if (nw !== 0) begin bad++; $display("FAIL src_oob_writes got=%0d exp=0", nw); end
      total++; if (er !== 1'b1) begin bad++; $display("FAIL src_oob_error got=%b exp=1", er); end
      total++; if (ram[50] !== 32'h5A00_0032) begin bad++; $display("FAIL src_oob_ram got=%0h exp=5a000032", ram[50]); end
      run_xfer(0, 125, 4, dc, nw, nb, er);
      total++; if (er !== 1'b1 || nw !== 0) begin bad++; $display("FAIL dst_oob got=err%b/wr%0d exp=err1/wr0", er, nw); end
      run_xfer(32'hFFFF_FFFE, 50, 4, dc, nw, nb, er);
      total++; if (er !== 1'b1 || nw !== 0) begin bad++; $display("FAIL src_wrap got=err%b/wr%0d exp=err1/wr0", er, nw); end
      run_xfer(0, 124, 4, dc, nw, nb, er);
      total++; if (er !== 1'b0 || dc !== 9) begin bad++; $display("FAIL dst_edge got=err%b/done%0d exp=err0/done9", er, dc); end
      total++; if (ram[124] !== 32'h5A00_0000) begin bad++; $display("FAIL dst_edge_first got=%0h exp=5a000000", ram[124]); end
      total++; if (ram[127] !== 32'h5A00_0003) begin bad++; $display("FAIL dst_edge_last got=%0h exp=5a000003", ram[127]); end
   endtask

   task automatic test_overlap();
      int dc, nw, nb; bit er;
      ram[5] <= 32'hC0FF_EE05;
      run_xfer(5, 6, 3, dc, nw, nb, er);
      total++; if (ram[6] !== 32'hC0FF_EE05) begin bad++; $display("FAIL overlap_6 got=%0h exp=c0ffee05", ram[6]); end
      total++; if (ram[7] !== 32'hC0FF_EE05) begin bad++; $display("FAIL overlap_7 got=%0h exp=c0ffee05", ram[7]); end
      total++; if (ram[8] !== 32'hC0FF_EE05) begin bad++; $display("FAIL overlap_8 got=%0h exp=c0ffee05", ram[8]); end
      total++; if (ram[9] !== 32'h5A00_0009) begin bad++; $display("FAIL overlap_9 got=%0h exp=5a000009", ram[9]); end
      total++; if (er !== 1'b0 || dc !== 7) begin bad++; $display("FAIL overlap_status got=err%b/done%0d exp=err0/done7", er, dc); end
   endtask

   // A second start mid-transfer and a start during DONE must both be dropped.
   task automatic test_ignore();
      int dc = 0;
      @(negedge clk);
      start_in = 1'b1; src_in = 10; dst_in = 60; len_in = 8'd4;
      @(negedge clk);
      start_in = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 3) begin start_in = 1'b1; src_in = 0; dst_in = 70; len_in = 8'd2; end
         else start_in = 1'b0;
         if (done_out) begin
            dc = c;
            start_in = 1'b1; src_in = 0; dst_in = 90; len_in = 8'd1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      start_in = 1'b0;
      total++; if (dc !== 9) begin bad++; $display("FAIL ignore_done_cycle got=%0d exp=9", dc); end
      total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL ignore_done_start got=%b exp=0", busy_out); end
      repeat (6) @(negedge clk);
      total++; if (ram[60] !== 32'h1111_AAAA || ram[63] !== 32'h4444_DDDD)
         begin bad++; $display("FAIL ignore_copy got=%0h/%0h exp=1111aaaa/4444dddd", ram[60], ram[63]); end
      total++; if (ram[70] !== 32'h5A00_0046) begin bad++; $display("FAIL ignore_busy_start got=%0h exp=5a000046", ram[70]); end
      total++; if (ram[90] !== 32'h5A00_005A) begin bad++; $display("FAIL ignore_dst90 got=%0h exp=5a00005a", ram[90]); end
   endtask

   task automatic test_abort();
      int seen = 0;
      @(negedge clk);
      start_in = 1'b1; src_in = 20; dst_in = 100; len_in = 8'd4;
      @(negedge clk);
      start_in = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;  // cycle 4: second write is on the port
      @(negedge clk);
      rst = 1'b0;
      total++; if (MemWrite_out !== 1'b0 || busy_out !== 1'b0)
         begin bad++; $display("FAIL abort_idle got=we%b/busy%b exp=we0/busy0", MemWrite_out, busy_out); end
      for (int c = 0; c < 12; c++) begin
         if (done_out || error_out || MemWrite_out) seen++;
         @(negedge clk);
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL abort_quiet got=%0d exp=0", seen); end
      total++; if (ram[100] !== 32'h5A00_0014) begin bad++; $display("FAIL abort_w0 got=%0h exp=5a000014", ram[100]); end
      total++; if (ram[101] !== 32'h5A00_0015) begin bad++; $display("FAIL abort_w1 got=%0h exp=5a000015", ram[101]); end
      total++; if (ram[102] !== 32'h5A00_0066) begin bad++; $display("FAIL abort_w2 got=%0h exp=5a000066", ram[102]); end
      total++; if (ram[103] !== 32'h5A00_0067) begin bad++; $display("FAIL abort_w3 got=%0h exp=5a000067", ram[103]); end
   endtask

`ifdef MEM_COPY_DMA_FILL_EN
   task automatic test_fill();
      int dc, nw, nb, wrong = 0; bit er;
      fill_mode_in = 1'b1; fill_pattern_in = 32'hDEAD_BEEF;
      run_xfer(32'hFFFF_FFFF, 0, 128, dc, nw, nb, er);
      fill_mode_in = 1'b0;
      for (int i = 0; i < DP; i++) if (ram[i] !== 32'hDEAD_BEEF) wrong++;
      total++; if (wrong !== 0) begin bad++; $display("FAIL fill_words got=%0d_wrong exp=0", wrong); end
      total++; if (dc !== 129) begin bad++; $display("FAIL fill_done got=%0d exp=129", dc); end
      total++; if (nw !== 128 || er !== 1'b0) begin bad++; $display("FAIL fill_status got=wr%0d/err%b exp=wr128/err0", nw, er); end
   endtask
`endif

   initial begin
`ifdef MEM_COPY_DMA_FILL_EN
      fill_mode_in = 1'b0; fill_pattern_in = '0;
`endif
      test_reset();
      test_copy();
      test_bounds();
      test_overlap();
      test_ignore();
      test_abort();
`ifdef MEM_COPY_DMA_FILL_EN
      test_fill();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
